// File: rtl/mem_pkg.sv
// Shared types and encodings for the wait-stated memory controller.
// The byte-enable helper maps an access to the RAM byte lanes it may write.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam int CNT_W = 4;

  // Misaligned words enable no lane, so such a write leaves the RAM untouched.
  function automatic logic [1:0] byte_en(input logic size, input logic a0);
    logic [1:0] be;
    if (size == SIZE_WORD) begin
      be = a0 ? 2'b00 : 2'b11;
    end else begin
      be = a0 ? 2'b10 : 2'b01;
    end
    return be;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with two byte-lane write enables.
// The read register resets to zero; the array contents are never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [1:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  logic [15:0] ram [WORDS];

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    if (en && (we == RW_WRITE)) begin
      if (be[0]) begin
        ram[addr][7:0] <= wdata[7:0];
      end
      if (be[1]) begin
        ram[addr][15:8] <= wdata[15:8];
      end
    end
  end

  // Read register: updated only by a completed read, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 16'h0000;
    end else if (en && (we == RW_READ)) begin
      rdata <= ram[addr];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-cycle memory controller: request latching, wait-state FSM and ready pulse.
// The RAM operation fires on the edge that enters DONE, so R and the data appear together.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEMEN,
  input  logic              R_W,
  input  logic              DATA_SIZE,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [15:0]       MDR_in,
  output logic [15:0]       mem_data,
  output logic              R,
  output logic              misalign
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rw_q;
  logic             size_q;
  logic [IDX_W:0]   mar_q;
  logic [15:0]      wd_q;

  logic             req_rw;
  logic             req_size;
  logic [IDX_W:0]   req_mar;
  logic [15:0]      req_wd;
  logic             go_done;
  logic             req_mis;
  logic [1:0]       req_be;
  logic [15:0]      req_wdata;

  // Address bits above the RAM depth only alias; they are deliberately dropped.
  logic unused_mar_hi;
  assign unused_mar_hi = ^MAR[ADDR_W-1:IDX_W+1];

  // Request view: live inputs on the accepting edge (needed when LATENCY is 1), latches after.
  always_comb begin
    req_rw   = rw_q;
    req_size = size_q;
    req_mar  = mar_q;
    req_wd   = wd_q;
    if (state == IDLE) begin
      req_rw   = R_W;
      req_size = DATA_SIZE;
      req_mar  = MAR[IDX_W:0];
      req_wd   = MDR_in;
    end else begin
      req_rw   = rw_q;
      req_size = size_q;
      req_mar  = mar_q;
      req_wd   = wd_q;
    end
    go_done   = MEMEN && (((state == IDLE) && (LATENCY == 1)) ||
                          ((state == BUSY) && (cnt == {CNT_W{1'b0}})));
    req_mis   = (req_size == SIZE_WORD) && req_mar[0];
    req_be    = byte_en(req_size, req_mar[0]);
    req_wdata = (req_size == SIZE_WORD) ? req_wd : {req_wd[7:0], req_wd[7:0]};
  end

  // Control FSM with wait-state counter, request latches and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      R        <= 1'b0;
      misalign <= 1'b0;
      rw_q     <= RW_READ;
      size_q   <= SIZE_BYTE;
      mar_q    <= {(IDX_W+1){1'b0}};
      wd_q     <= 16'h0000;
    end else begin
      R        <= go_done;
      misalign <= go_done && req_mis;
      case (state)
        IDLE: begin
          if (MEMEN) begin
            rw_q   <= R_W;
            size_q <= DATA_SIZE;
            mar_q  <= MAR[IDX_W:0];
            wd_q   <= MDR_in;
            if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        BUSY: begin
          if (!MEMEN) begin
            state <= IDLE;
          end else if (cnt == {CNT_W{1'b0}}) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (go_done),
    .we    (req_rw),
    .be    (req_be),
    .addr  (req_mar[IDX_W:1]),
    .wdata (req_wdata),
    .rdata (mem_data)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed table, multi-cycle corner sequences,
// and random accesses checked against a word-array reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEMEN, memen1;
  logic        R_W, DATA_SIZE;
  logic [15:0] MAR, MDR_in;
  logic [15:0] mem_data, mem_data1;
  logic        R, misalign, r1, mis1;

  mem_ctrl #(.ADDR_W(16), .MEM_WORDS(1024), .LATENCY(4)) dut (
    .clk(clk), .reset(reset), .MEMEN(MEMEN), .R_W(R_W), .DATA_SIZE(DATA_SIZE),
    .MAR(MAR), .MDR_in(MDR_in), .mem_data(mem_data), .R(R), .misalign(misalign)
  );

  mem_ctrl #(.ADDR_W(16), .MEM_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .MEMEN(memen1), .R_W(R_W), .DATA_SIZE(DATA_SIZE),
    .MAR(MAR), .MDR_in(MDR_in), .mem_data(mem_data1), .R(r1), .misalign(mis1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        size;
    logic [15:0] mar;
    logic [15:0] wd;
    logic [15:0] exp_d;
    logic        exp_m;
  } vec_t;

  int          vecs = 0;
  int          errs = 0;
  logic [15:0] model [1024];
  logic [15:0] last_md;
  vec_t        tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % 1024;
  endfunction

  task automatic model_apply(input logic rw, input logic size, input logic [15:0] mar,
                             input logic [15:0] wd);
    int i;
    logic [15:0] w;
    i = widx(mar);
    w = model[i];
    if (rw) begin
      if (size) begin
        if (int'(mar) % 2 == 0) w = wd;
      end else if (int'(mar) % 2 == 1) begin
        w = (w % 256) + (wd % 256) * 256;
      end else begin
        w = (w / 256) * 256 + (wd % 256);
      end
      model[i] = w;
    end else begin
      last_md = w;
    end
  endtask

  task automatic do_access(input logic rw, input logic size, input logic [15:0] mar,
                           input logic [15:0] wd, input logic [15:0] exp_d,
                           input logic exp_m, input string name);
    int n;
    R_W = rw; DATA_SIZE = size; MAR = mar; MDR_in = wd; MEMEN = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        R_W = 1'($urandom); DATA_SIZE = 1'($urandom);
        MAR = 16'($urandom); MDR_in = 16'($urandom);
      end
    end while (R !== 1'b1 && n < 20);
    chk({name, " latency"}, (R === 1'b1) ? n : 0, 4);
    chk({name, " misalign"}, misalign, exp_m);
    chk({name, " mem_data"}, mem_data, exp_d);
    MEMEN = 1'b0;
    model_apply(rw, size, mar, wd);
    @(posedge clk); #1;
    chk({name, " R pulse width"}, R, 0);
  endtask

  initial begin
    int q[$];
    bit seen;
    int n;
    logic rw, size;
    logic [15:0] mar, wd, ed;

    reset = 1'b1; MEMEN = 1'b0; memen1 = 1'b0;
    R_W = 1'b0; DATA_SIZE = 1'b0; MAR = 16'h0000; MDR_in = 16'h0000;
    last_md = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset R", R, 0);
    chk("reset misalign", misalign, 0);
    chk("reset mem_data", mem_data, 16'h0000);
    chk("reset R lat1", r1, 0);
    reset = 1'b0;

    for (int i = 0; i < 1024; i++)
      do_access(1'b1, 1'b1, 16'(i * 2), 16'(i) ^ 16'h5A5A, last_md, 1'b0, "prefill");

    tbl[0]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0011, 16'h0012, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h12EF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0010, 16'h0034, 16'h12EF, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'h0021, 16'hAAAA, 16'h1234, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'h5A4A, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h0021, 16'h0000, 16'h5A4A, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 16'hFFFE, 16'hC0DE, 16'h5A4A, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h07FE, 16'h0000, 16'hC0DE, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0013, 16'h0000, 16'h5A53, 1'b0};
    for (int i = 0; i < 12; i++)
      do_access(tbl[i].rw, tbl[i].size, tbl[i].mar, tbl[i].wd,
                tbl[i].exp_d, tbl[i].exp_m, $sformatf("table[%0d]", i));

    // Abort: MEMEN dropped two edges into a write.
    R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h0040; MDR_in = 16'hFFFF; MEMEN = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    MEMEN = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (R === 1'b1) seen = 1'b1; end
    chk("abort no R", seen, 0);
    chk("abort mem_data held", mem_data, last_md);
    do_access(1'b0, 1'b1, 16'h0040, 16'h0000, model[widx(16'h0040)], 1'b0, "after abort");

    // Reset in BUSY with a pending write.
    R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h0030; MDR_in = 16'h1111; MEMEN = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1; #1;
    chk("busy reset R", R, 0);
    chk("busy reset mem_data", mem_data, 16'h0000);
    MEMEN = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; last_md = 16'h0000;
    do_access(1'b0, 1'b1, 16'h0030, 16'h0000, model[widx(16'h0030)], 1'b0, "after busy reset");

    // Reset in DONE on a misaligned read: R and misalign drop at once.
    R_W = 1'b0; DATA_SIZE = 1'b1; MAR = 16'h0021; MEMEN = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (R !== 1'b1 && n < 20);
    chk("done reset reached R", n, 4);
    chk("done reset misalign before", misalign, 1);
    reset = 1'b1; #1;
    chk("done reset R", R, 0);
    chk("done reset misalign", misalign, 0);
    chk("done reset mem_data", mem_data, 16'h0000);
    MEMEN = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; last_md = 16'h0000;
    do_access(1'b0, 1'b1, 16'h0010, 16'h0000, model[widx(16'h0010)], 1'b0, "after done reset");

    // MEMEN held high: pulses every LATENCY+1 edges.
    R_W = 1'b0; DATA_SIZE = 1'b1; MAR = 16'h0010; MEMEN = 1'b1;
    for (int e = 1; e <= 40 && q.size() < 3; e++) begin
      @(posedge clk); #1;
      if (R === 1'b1) q.push_back(e);
    end
    MEMEN = 1'b0;
    chk("continuous pulse count", q.size(), 3);
    if (q.size() >= 3) begin
      chk("continuous first", q[0], 4);
      chk("continuous spacing 1", q[1] - q[0], 5);
      chk("continuous spacing 2", q[2] - q[1], 5);
    end
    last_md = model[widx(16'h0010)];
    @(posedge clk); #1;

    // LATENCY=1 instance.
    R_W = 1'b1; DATA_SIZE = 1'b1; MAR = 16'h0002; MDR_in = 16'h7777; memen1 = 1'b1;
    @(posedge clk); #1;
    chk("lat1 write R", r1, 1);
    memen1 = 1'b0;
    @(posedge clk); #1;
    chk("lat1 R drop", r1, 0);
    R_W = 1'b0; memen1 = 1'b1;
    @(posedge clk); #1;
    chk("lat1 read R", r1, 1);
    chk("lat1 read data", mem_data1, 16'h7777);
    @(posedge clk); #1;
    chk("lat1 continuous gap", r1, 0);
    @(posedge clk); #1;
    chk("lat1 continuous next", r1, 1);
    memen1 = 1'b0;
    @(posedge clk); #1;

    // Random accesses against the reference model.
    repeat (150) begin
      rw = 1'($urandom); size = 1'($urandom);
      mar = 16'($urandom); wd = 16'($urandom);
      ed = rw ? last_md : model[widx(mar)];
      do_access(rw, size, mar, wd, ed, size && (int'(mar) % 2 == 1), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
